// File: rtl/chroma_key_pipe.sv
// Three-stage chroma keyer: scores the key channel against the other two and
// replaces strongly keyed pixels with black or a supplied background colour.
module chroma_key_pipe #(
    parameter int DW             = 8,
    parameter int KEY_CH         = 1,
    parameter int PASS_W         = 24,
    parameter int CNT_W          = 20,
    parameter int THRESH_DEFAULT = 82906
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DW-1:0]     r,
    input  logic [DW-1:0]     g,
    input  logic [DW-1:0]     b,
    input  logic [PASS_W-1:0] pass_in,
    input  logic              key_en,
    input  logic              bg_sel,
    input  logic [DW-1:0]     bg_r,
    input  logic [DW-1:0]     bg_g,
    input  logic [DW-1:0]     bg_b,
    input  logic              thr_wr,
    input  logic [3*DW+2:0]   thr_in,
    input  logic              frame_start,
    output logic              out_valid,
    output logic [DW-1:0]     outR,
    output logic [DW-1:0]     outG,
    output logic [DW-1:0]     outB,
    output logic [PASS_W-1:0] pass_thru,
    output logic [CNT_W-1:0]  key_count,
    output logic              keyed
);
    localparam int TW = 3*DW+3;

    logic [DW-1:0] k_in, o1_in, o2_in;
    logic signed [DW:0] d1_in, d2_in;

    always_comb begin
        k_in  = g;
        o1_in = r;
        o2_in = b;
        case (KEY_CH)
            0: begin k_in = r; o1_in = g; o2_in = b; end
            2: begin k_in = b; o1_in = r; o2_in = g; end
            default: begin k_in = g; o1_in = r; o2_in = b; end
        endcase
    end

    assign d1_in = $signed({1'b0, k_in}) - $signed({1'b0, o1_in});
    assign d2_in = $signed({1'b0, k_in}) - $signed({1'b0, o2_in});

    // S1
    logic                v1, ken1, bgs1;
    logic [DW-1:0]       r1, g1, b1, k1, bgr1, bgg1, bgb1;
    logic signed [DW:0]  d1_1, d2_1;
    logic [PASS_W-1:0]   pass1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0; ken1 <= 1'b0; bgs1 <= 1'b0;
            r1 <= '0; g1 <= '0; b1 <= '0; k1 <= '0;
            bgr1 <= '0; bgg1 <= '0; bgb1 <= '0;
            d1_1 <= '0; d2_1 <= '0; pass1 <= '0;
        end else begin
            v1 <= in_valid; ken1 <= key_en; bgs1 <= bg_sel;
            r1 <= r; g1 <= g; b1 <= b; k1 <= k_in;
            bgr1 <= bg_r; bgg1 <= bg_g; bgb1 <= bg_b;
            d1_1 <= d1_in; d2_1 <= d2_in; pass1 <= pass_in;
        end
    end

    // Both differences strictly positive, so their low DW bits are the magnitudes.
    logic            both_pos;
    logic [2*DW-1:0] prod_s1;
    assign both_pos = !d1_1[DW] && (d1_1 != '0) && !d2_1[DW] && (d2_1 != '0);
    assign prod_s1  = both_pos ? ({{DW{1'b0}}, d1_1[DW-1:0]} * {{DW{1'b0}}, d2_1[DW-1:0]}) : '0;

    // S2
    logic              v2, ken2, bgs2;
    logic [DW-1:0]     r2, g2, b2, k2, bgr2, bgg2, bgb2;
    logic [2*DW-1:0]   prod2;
    logic [PASS_W-1:0] pass2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2 <= 1'b0; ken2 <= 1'b0; bgs2 <= 1'b0;
            r2 <= '0; g2 <= '0; b2 <= '0; k2 <= '0;
            bgr2 <= '0; bgg2 <= '0; bgb2 <= '0;
            prod2 <= '0; pass2 <= '0;
        end else begin
            v2 <= v1; ken2 <= ken1; bgs2 <= bgs1;
            r2 <= r1; g2 <= g1; b2 <= b1; k2 <= k1;
            bgr2 <= bgr1; bgg2 <= bgg1; bgb2 <= bgb1;
            prod2 <= prod_s1; pass2 <= pass1;
        end
    end

    logic [TW-1:0]    thr_q, score, k_ext, p_ext;
    logic             hit, inc;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;

    assign k_ext   = TW'(k2);
    assign p_ext   = TW'(prod2);
    assign score   = k_ext * p_ext;
    assign hit     = ken2 && (score > thr_q);
    assign inc     = v2 && hit;
    assign cnt_nxt = (inc && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_q <= TW'(THRESH_DEFAULT);
        end else if (thr_wr) begin
            thr_q <= thr_in;
        end
    end

    // S3: output register and keyed-pixel counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0; keyed <= 1'b0;
            outR <= '0; outG <= '0; outB <= '0; pass_thru <= '0;
            cnt_q <= '0; key_count <= '0;
        end else begin
            out_valid <= v2;
            keyed     <= inc;
            pass_thru <= pass2;
            if (hit) begin
                outR <= bgs2 ? bgr2 : '0;
                outG <= bgs2 ? bgg2 : '0;
                outB <= bgs2 ? bgb2 : '0;
            end else begin
                outR <= r2; outG <= g2; outB <= b2;
            end
            if (frame_start) begin
                key_count <= cnt_nxt;
                cnt_q     <= '0;
            end else begin
                cnt_q <= cnt_nxt;
            end
        end
    end
endmodule

// File: tb/tb_chroma_key_pipe.sv
// Directed bench for chroma_key_pipe (default parameters, key channel G).
module tb_chroma_key_pipe;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  r = '0, g = '0, b = '0;
    logic [23:0] pass_in = '0;
    logic        key_en = 1'b0, bg_sel = 1'b0;
    logic [7:0]  bg_r = '0, bg_g = '0, bg_b = '0;
    logic        thr_wr = 1'b0;
    logic [26:0] thr_in = '0;
    logic        frame_start = 1'b0;
    logic        out_valid, keyed;
    logic [7:0]  out_r, out_g, out_b;
    logic [23:0] pass_thru;
    logic [19:0] key_count;

    int checks = 0;
    int errors = 0;

    chroma_key_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .r(r), .g(g), .b(b), .pass_in(pass_in),
        .key_en(key_en), .bg_sel(bg_sel),
        .bg_r(bg_r), .bg_g(bg_g), .bg_b(bg_b),
        .thr_wr(thr_wr), .thr_in(thr_in), .frame_start(frame_start),
        .out_valid(out_valid), .outR(out_r), .outG(out_g), .outB(out_b),
        .pass_thru(pass_thru), .key_count(key_count), .keyed(keyed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] r, g, b;
        logic       en, bs;
        logic [7:0] br, bgc, bb;
        logic [7:0] er, eg, eb;
        logic       ek;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(input logic [7:0] r_i, g_i, b_i, input logic en_i, bs_i,
                                input logic [7:0] br_i, bg_i, bb_i,
                                input logic [7:0] er_i, eg_i, eb_i, input logic ek_i);
        vec_t v;
        v.r = r_i; v.g = g_i; v.b = b_i; v.en = en_i; v.bs = bs_i;
        v.br = br_i; v.bgc = bg_i; v.bb = bb_i;
        v.er = er_i; v.eg = eg_i; v.eb = eb_i; v.ek = ek_i;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive(input logic [7:0] r_i, g_i, b_i, input logic en_i, bs_i,
                         input logic [7:0] br_i, bg_i, bb_i, input logic [23:0] p_i);
        in_valid = 1'b1; r = r_i; g = g_i; b = b_i; key_en = en_i; bg_sel = bs_i;
        bg_r = br_i; bg_g = bg_i; bg_b = bb_i; pass_in = p_i;
    endtask

    task automatic write_thr(input logic [26:0] v);
        thr_wr = 1'b1; thr_in = v;
        tick();
        thr_wr = 1'b0;
    endtask

    task automatic check_out(input string name, input logic [7:0] er, eg, eb, input logic ek);
        chk({name, "_valid"}, 32'(out_valid), 32'd1);
        chk({name, "_keyed"}, 32'(keyed), 32'(ek));
        chk({name, "_rgb"}, {8'd0, out_r, out_g, out_b}, {8'd0, er, eg, eb});
    endtask

    task automatic send_and_check(input string name, input logic [7:0] r_i, g_i, b_i,
                                  input logic en_i, bs_i, input logic [7:0] er, eg, eb,
                                  input logic ek);
        drive(r_i, g_i, b_i, en_i, bs_i, 8'd10, 8'd20, 8'd30, 24'h0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check_out(name, er, eg, eb, ek);
    endtask

    logic [7:0] pat;
    int k_lo, k_hi;

    initial begin
        vecs[0]  = mk(50, 200, 50, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[1]  = mk(40, 60, 40, 1, 0, 0, 0, 0, 40, 60, 40, 0);
        vecs[2]  = mk(200, 50, 200, 1, 0, 0, 0, 0, 200, 50, 200, 0);
        vecs[3]  = mk(50, 200, 50, 1, 1, 10, 20, 30, 10, 20, 30, 1);
        vecs[4]  = mk(50, 200, 50, 0, 1, 10, 20, 30, 50, 200, 50, 0);
        vecs[5]  = mk(50, 200, 50, 1, 0, 10, 20, 30, 0, 0, 0, 1);
        vecs[6]  = mk(100, 100, 0, 1, 0, 0, 0, 0, 100, 100, 0, 0);
        vecs[7]  = mk(0, 255, 255, 1, 0, 0, 0, 0, 0, 255, 255, 0);
        vecs[8]  = mk(11, 51, 11, 1, 0, 0, 0, 0, 11, 51, 11, 0);
        vecs[9]  = mk(20, 60, 20, 1, 1, 1, 2, 3, 1, 2, 3, 1);
        vecs[10] = mk(0, 255, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        vecs[11] = mk(10, 100, 200, 1, 0, 0, 0, 0, 10, 100, 200, 0);

        // reset state
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_keyed", 32'(keyed), 32'd0);
        chk("rst_rgb", {8'd0, out_r, out_g, out_b}, 32'd0);
        chk("rst_pass", 32'(pass_thru), 32'd0);
        chk("rst_count", 32'(key_count), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // streamed table, one pixel per clock
        for (int k = 0; k < 15; k++) begin
            if (k >= 3)
                check_out($sformatf("vec%0d", k - 3), vecs[k-3].er, vecs[k-3].eg,
                          vecs[k-3].eb, vecs[k-3].ek);
            if (k < 12)
                drive(vecs[k].r, vecs[k].g, vecs[k].b, vecs[k].en, vecs[k].bs,
                      vecs[k].br, vecs[k].bgc, vecs[k].bb, 24'(k));
            else
                in_valid = 1'b0;
            tick();
        end
        idle(3);

        // threshold boundary
        write_thr(27'd4500000);
        send_and_check("thr_equal", 50, 200, 50, 1, 0, 50, 200, 50, 0);
        write_thr(27'd4499999);
        send_and_check("thr_below", 50, 200, 50, 1, 0, 0, 0, 0, 1);
        drive(50, 200, 50, 1, 0, 0, 0, 0, 24'h0);
        tick();
        in_valid = 1'b0;
        tick();
        thr_wr = 1'b1; thr_in = 27'd5000000;
        tick();
        thr_wr = 1'b0;
        check_out("thr_old_used", 0, 0, 0, 1);
        send_and_check("thr_new_used", 50, 200, 50, 1, 0, 50, 200, 50, 0);
        write_thr(27'd82906);
        idle(3);

        // valid pattern and sideband alignment
        pat = 8'b10110111;
        for (int k = 0; k < 11; k++) begin
            if (k >= 3 && pat[7-(k-3)]) begin
                chk($sformatf("burst_valid%0d", k), 32'(out_valid), 32'd1);
                chk($sformatf("burst_pass%0d", k), 32'(pass_thru), 32'(k - 3));
            end else begin
                chk($sformatf("burst_valid%0d", k), 32'(out_valid), 32'd0);
                chk($sformatf("burst_keyed%0d", k), 32'(keyed), 32'd0);
            end
            if (k < 8) begin
                drive(1, 2, 3, 1, 0, 0, 0, 0, 24'(k));
                in_valid = pat[7-k];
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end

        // frame counting: K N K N K N K K, frame_start as the last one exits
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        pat = 8'b10101011;
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                if (pat[7-k]) drive(50, 200, 50, 1, 0, 0, 0, 0, 24'(k));
                else          drive(40, 60, 40, 1, 0, 0, 0, 0, 24'(k));
            end else begin
                in_valid = 1'b0;
            end
            frame_start = (k == 9);
            tick();
        end
        frame_start = 1'b0;
        chk("count_frame1", 32'(key_count), 32'd5);
        check_out("count_last_px", 0, 0, 0, 1);
        send_and_check("count_f2a", 50, 200, 50, 1, 0, 0, 0, 0, 1);
        send_and_check("count_f2b", 50, 200, 50, 1, 0, 0, 0, 0, 1);
        chk("count_hold", 32'(key_count), 32'd5);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("count_frame2", 32'(key_count), 32'd2);

        // reset mid-burst with a low threshold in place
        write_thr(27'd1000);
        for (int k = 0; k < 5; k++) begin
            drive(40, 60, 40, 1, 1, 10, 20, 30, 24'(k + 100));
            tick();
        end
        check_out("prerst", 10, 20, 30, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_keyed", 32'(keyed), 32'd0);
        chk("midrst_rgb", {8'd0, out_r, out_g, out_b}, 32'd0);
        chk("midrst_pass", 32'(pass_thru), 32'd0);
        chk("midrst_count", 32'(key_count), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        k_lo = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (out_valid !== 1'b0) k_lo++;
        end
        chk("postrst_stale", 32'(k_lo), 32'd0);
        send_and_check("postrst_thr_hi", 20, 60, 20, 1, 0, 0, 0, 0, 1);
        send_and_check("postrst_thr_lo", 11, 51, 11, 1, 0, 11, 51, 11, 0);
        k_hi = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
